// File: rtl/melody_sequencer.sv
// Note-ROM melody player: holds each note for dur beat ticks, gates the tone stage off
// for the last GAP_CYC cycles of each note, with start/stop control and optional looping.
module melody_sequencer #(
  parameter int BEAT_DIV = 3000000,
  parameter int GAP_CYC  = 300000,
  parameter int ADDR_W   = 6
) (
  input  logic              clk12M,
  input  logic              Rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [3:0]        tune,
  output logic              note_on,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(BEAT_DIV);
  localparam logic [BW-1:0]     BEAT_LAST = BW'(BEAT_DIV - 1);
  // One extra bit so GAP_CYC=0 yields a threshold the counter can never reach.
  localparam logic [BW:0]       GAP_START = (BW+1)'(BEAT_DIV - GAP_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  // Entry = {tune, dur}; dur==0 terminates the song.
  function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    case (ai)
      0:       rom = 8'h62;
      1:       rom = 8'h61;
      2:       rom = 8'h71;
      3:       rom = 8'h44;
      4:       rom = 8'h62;
      5:       rom = 8'h61;
      6:       rom = 8'h71;
      7:       rom = 8'h54;
      8:       rom = 8'h42;
      9:       rom = 8'h32;
      10:      rom = 8'h84;
      default: rom = 8'h00;
    endcase
  endfunction

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [3:0]        rem_q, rem_d;
  logic [3:0]        tune_q, tune_d;
  logic              on_q, on_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] nxt_idx;
  logic [7:0]        nxt_e, first_e;
  logic              tick;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    rem_d   = rem_q;
    tune_d  = tune_q;
    done_d  = 1'b0;
    nxt_idx = idx_q + 1'b1;
    nxt_e   = rom(nxt_idx);
    first_e = rom('0);
    tick    = (beat_q == BEAT_LAST);

    if (stop) begin
      state_d = S_IDLE;
      beat_d  = '0;
      rem_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        if (first_e[3:0] == 4'd0) begin
          done_d = 1'b1;
        end else begin
          state_d = S_PLAY;
          idx_d   = '0;
          beat_d  = '0;
          rem_d   = first_e[3:0];
          tune_d  = first_e[7:4];
        end
      end
    end else begin
      beat_d = tick ? '0 : beat_q + 1'b1;
      if (tick) begin
        if (rem_q > 4'd1) begin
          rem_d = rem_q - 4'd1;
        end else if (nxt_e[3:0] == 4'd0 || idx_q == ADDR_LAST) begin
          if (loop_en) begin
            idx_d  = '0;
            rem_d  = first_e[3:0];
            tune_d = first_e[7:4];
          end else begin
            state_d = S_IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = nxt_idx;
          rem_d  = nxt_e[3:0];
          tune_d = nxt_e[7:4];
        end
      end
    end

    // Derived from next-state values so the gate stays aligned with tune.
    on_d = (state_d == S_PLAY) && !(rem_d == 4'd1 && {1'b0, beat_d} >= GAP_START);
  end

  always_ff @(posedge clk12M or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      rem_q   <= '0;
      tune_q  <= '0;
      on_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      rem_q   <= rem_d;
      tune_q  <= tune_d;
      on_q    <= on_d;
      done_q  <= done_d;
    end
  end

  assign tune     = tune_q;
  assign note_on  = on_q;
  assign note_idx = idx_q;
  assign busy     = (state_q == S_PLAY);
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed vector table, hand-written corner sequences,
// and a randomized run checked against a song-timeline reference model.
module tb_melody_sequencer;
  localparam int BD  = 10;
  localparam int GAP = 2;
  localparam int AW  = 6;

  logic clk = 1'b0;
  logic rst, start, stop, loop_en;
  logic [3:0] tune, tune0;
  logic note_on, note_on0, busy, busy0, done, done0;
  logic [AW-1:0] note_idx, note_idx0;

  always #5 clk = ~clk;

  melody_sequencer #(.BEAT_DIV(BD), .GAP_CYC(GAP), .ADDR_W(AW)) dut (
    .clk12M(clk), .Rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .tune(tune), .note_on(note_on), .note_idx(note_idx), .busy(busy), .done(done));

  melody_sequencer #(.BEAT_DIV(BD), .GAP_CYC(0), .ADDR_W(AW)) dut0 (
    .clk12M(clk), .Rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .tune(tune0), .note_on(note_on0), .note_idx(note_idx0), .busy(busy0), .done(done0));

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string name, int et, int eo, int eb, int ed, int ei);
    chk({name, ".tune"}, int'(tune), et);
    chk({name, ".note_on"}, int'(note_on), eo);
    chk({name, ".busy"}, int'(busy), eb);
    chk({name, ".done"}, int'(done), ed);
    chk({name, ".note_idx"}, int'(note_idx), ei);
  endtask

  // One clock edge with the given control inputs; outputs sampled 1 time unit later.
  task automatic step(bit st, bit sp, bit le);
    @(negedge clk);
    start = st; stop = sp; loop_en = le;
    @(posedge clk);
    #1;
  endtask

  // Song contents and expanded per-cycle timeline of a playback started at cycle 0.
  int rom_t[12] = '{8'h62, 8'h61, 8'h71, 8'h44, 8'h62, 8'h61, 8'h71, 8'h54,
                    8'h42, 8'h32, 8'h84, 8'h00};
  int tl_tune[$], tl_idx[$];
  bit tl_on[$], tl_on0[$];
  int L;

  typedef struct {
    bit st, sp, le;
    int n;
    int tune, on, busy, done, idx;
  } vec_t;
  vec_t tbl[16];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, seen_done;
    bit playing, mdone;
    int p, mtune, midx;
    bit st, sp, le;

    for (int i = 0; i < 12; i++) begin
      int dur, len;
      dur = rom_t[i] & 15;
      if (dur == 0) break;
      len = dur * BD;
      for (int j = 0; j < len; j++) begin
        tl_tune.push_back(rom_t[i] >> 4);
        tl_idx.push_back(i);
        tl_on.push_back(j < len - GAP);
        tl_on0.push_back(1'b1);
      end
    end
    L = tl_tune.size();
    chk("song_length", L, 240);

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    //           st sp le  n  tune on busy done idx
    tbl[0]  = '{1, 0, 0,  1, 6, 1, 1, 0, 0};   // cycle 0
    tbl[1]  = '{0, 0, 0, 17, 6, 1, 1, 0, 0};   // 17
    tbl[2]  = '{0, 0, 0,  1, 6, 0, 1, 0, 0};   // 18 gap
    tbl[3]  = '{0, 0, 0,  1, 6, 0, 1, 0, 0};   // 19 gap
    tbl[4]  = '{0, 0, 0,  1, 6, 1, 1, 0, 1};   // 20 note 1
    tbl[5]  = '{0, 0, 0,  8, 6, 0, 1, 0, 1};   // 28 gap
    tbl[6]  = '{0, 0, 0,  2, 7, 1, 1, 0, 2};   // 30 note 2
    tbl[7]  = '{0, 0, 0, 10, 4, 1, 1, 0, 3};   // 40 note 3
    tbl[8]  = '{1, 0, 0,  1, 4, 1, 1, 0, 3};   // 41 start ignored
    tbl[9]  = '{0, 0, 0, 37, 4, 0, 1, 0, 3};   // 78 gap
    tbl[10] = '{0, 0, 0,  1, 4, 0, 1, 0, 3};   // 79 gap
    tbl[11] = '{0, 0, 0,  1, 6, 1, 1, 0, 4};   // 80 note 4
    tbl[12] = '{0, 1, 0,  1, 6, 0, 0, 0, 4};   // stop: hold tune/idx
    tbl[13] = '{1, 1, 0,  1, 6, 0, 0, 0, 4};   // start+stop: stop wins
    tbl[14] = '{1, 0, 0,  1, 6, 1, 1, 0, 0};   // replay from entry 0
    tbl[15] = '{0, 1, 0,  1, 6, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].st, tbl[k].sp, tbl[k].le);
      for (int c = 1; c < tbl[k].n; c++) step(1'b0, 1'b0, tbl[k].le);
      chk_out($sformatf("vec%0d", k), tbl[k].tune, tbl[k].on, tbl[k].busy, tbl[k].done, tbl[k].idx);
    end

    // Full song without looping; the GAP_CYC=0 instance must stay gated on throughout.
    bad = 0; seen_done = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < L - 1; c++) begin
      if (note_on0 !== 1'b1) bad++;
      if (done) seen_done++;
      step(1'b0, 1'b0, 1'b0);
    end
    if (note_on0 !== 1'b1) bad++;
    chk("legato_note_on", bad, 0);
    chk("no_early_done", seen_done, 0);
    chk_out("last_note", 8, 0, 1, 0, 10);
    step(1'b0, 1'b0, 1'b0);
    chk_out("song_end", 8, 0, 0, 1, 10);
    step(1'b0, 1'b0, 1'b0);
    chk_out("done_pulse_end", 8, 0, 0, 0, 10);

    // Looping playback wraps seamlessly and never pulses done.
    seen_done = 0;
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < L - 1; c++) begin
      if (done) seen_done++;
      step(1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_out("loop_wrap", 6, 1, 1, 0, 0);
    for (int c = 0; c < 60; c++) begin
      if (done) seen_done++;
      step(1'b0, 1'b0, 1'b1);
    end
    chk("loop_no_done", seen_done, 0);
    step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-note.
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 33; c++) step(1'b0, 1'b0, 1'b0);
    chk("pre_reset_tune", int'(tune), 7);
    #2 rst = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the timeline model.
    playing = 0; mdone = 0; p = 0; mtune = 0; midx = 0; le = 0;
    for (int c = 0; c < 3000 && fails < 40; c++) begin
      st = ($urandom % 30) == 0;
      sp = ($urandom % 200) == 0;
      if (($urandom % 100) == 0) le = ~le;
      step(st, sp, le);
      mdone = 0;
      if (sp) playing = 0;
      else if (!playing) begin
        if (st) begin playing = 1; p = 0; end
      end else begin
        p++;
        if (p == L) begin
          if (le) p = 0;
          else begin playing = 0; mdone = 1; end
        end
      end
      if (playing) begin mtune = tl_tune[p]; midx = tl_idx[p]; end
      chk_out($sformatf("rand%0d", c), mtune, playing ? int'(tl_on[p]) : 0,
              int'(playing), int'(mdone), midx);
      chk($sformatf("rand%0d.gap0_on", c), int'(note_on0), playing ? int'(tl_on0[p]) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
